// File: rtl/reg_spill_ctrl_pkg.sv
// reg_ctrl_pkg
// Shared types for the register spill/fill sequencer:
//   state_t    - sequencer states
//   MODE_SPILL - register file -> data memory
//   MODE_FILL  - data memory -> register file
package reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic MODE_SPILL = 1'b0;
  localparam logic MODE_FILL  = 1'b1;

endpackage

// File: rtl/reg_spill_ctrl_if.sv
// reg_spill_ctrl_if
// Data-memory port used by the spill/fill sequencer.
//   MEM_REQ   - request, held until MEM_ACK
//   MEM_WE    - 1 = write (spill), 0 = read (fill)
//   MEM_ADDR  - word address
//   MEM_WDATA - write data
//   MEM_RDATA - read data, valid together with MEM_ACK
//   MEM_ACK   - request complete (may arrive in the same cycle as MEM_REQ)
// Modports: master = sequencer side, slave = memory side.
interface reg_spill_ctrl_if #(
  parameter int W  = 8,
  parameter int AW = 8
) ();

  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [W-1:0]  MEM_WDATA;
  logic [W-1:0]  MEM_RDATA;
  logic          MEM_ACK;

  modport master (
    output MEM_REQ,
    output MEM_WE,
    output MEM_ADDR,
    output MEM_WDATA,
    input  MEM_RDATA,
    input  MEM_ACK
  );

  modport slave (
    input  MEM_REQ,
    input  MEM_WE,
    input  MEM_ADDR,
    input  MEM_WDATA,
    output MEM_RDATA,
    output MEM_ACK
  );

endinterface

// File: rtl/reg_spill_ctrl.sv
// reg_spill_ctrl
// Saves (spill) or restores (fill) a contiguous, possibly wrapping, range of
// register-file entries to/from data memory for context save. While BUSY the
// sequencer owns the register-file index and write strobes; the core stalls.
// Ports:
//   CLK, RESET           - clock, asynchronous active-high reset
//   START, MODE          - start request (IDLE only), 0 = spill / 1 = fill
//   FIRST_REG, LAST_REG  - inclusive register range, wraps 15 -> 0
//   BASE_ADDR            - memory address of FIRST_REG
//   BUSY, DONE           - busy flag, one-cycle completion pulse
//   RF_INDEX, RF_REG_WRITE, RF_ACC_WRITE, RF_IMME, RF_DATA - reg file controls
//   RF_REG_IN, RF_ACC_IN - reg file read data (register / accumulator)
//   mem                  - data-memory port (master side)
module reg_spill_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          MODE,
  input  logic [D-1:0]  FIRST_REG,
  input  logic [D-1:0]  LAST_REG,
  input  logic [AW-1:0] BASE_ADDR,
  output logic          BUSY,
  output logic          DONE,
  output logic [D-1:0]  RF_INDEX,
  output logic          RF_REG_WRITE,
  output logic          RF_ACC_WRITE,
  output logic          RF_IMME,
  output logic [W-1:0]  RF_DATA,
  input  logic [W-1:0]  RF_REG_IN,
  input  logic [W-1:0]  RF_ACC_IN,
  reg_spill_ctrl_if.master mem
);

  state_t        state;
  state_t        next_state;
  logic          mode;
  logic [D-1:0]  last;
  logic [D-1:0]  cur;
  logic [AW-1:0] addr;
  logic [W-1:0]  data;

  logic          cur_is_acc;
  logic          at_last;

  assign cur_is_acc = (cur == '0);
  assign at_last    = (cur == last);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latched configuration and transfer datapath. Mode and end index are
  // captured only on an accepted START so input changes mid-run are harmless.
  // Index and address advance in WB only when more registers remain, so both
  // wrap naturally at their own widths.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode <= MODE_SPILL;
      last <= '0;
      cur  <= '0;
      addr <= '0;
      data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            mode <= MODE;
            last <= LAST_REG;
            cur  <= FIRST_REG;
            addr <= BASE_ADDR;
          end
        end
        REQ: begin
          if (mem.MEM_ACK && (mode == MODE_FILL)) begin
            data <= mem.MEM_RDATA;
          end
        end
        WB: begin
          if (!at_last) begin
            cur  <= cur + D'(1);
            addr <= addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode. The accumulator lives at index 0 and has
  // its own read port and write strobe, so both the spill data mux and the
  // fill write strobe select on cur == 0.
  always_comb begin
    next_state    = state;
    BUSY          = (state != IDLE);
    DONE          = 1'b0;
    RF_INDEX      = '0;
    RF_REG_WRITE  = 1'b0;
    RF_ACC_WRITE  = 1'b0;
    RF_IMME       = 1'b0;
    RF_DATA       = '0;
    mem.MEM_REQ   = 1'b0;
    mem.MEM_WE    = 1'b0;
    mem.MEM_ADDR  = '0;
    mem.MEM_WDATA = '0;

    if (state != IDLE) begin
      RF_INDEX = cur;
    end

    case (state)
      IDLE: begin
        if (START) begin
          next_state = REQ;
        end
      end
      REQ: begin
        mem.MEM_REQ   = 1'b1;
        mem.MEM_WE    = (mode == MODE_SPILL);
        mem.MEM_ADDR  = addr;
        mem.MEM_WDATA = cur_is_acc ? RF_ACC_IN : RF_REG_IN;
        if (mem.MEM_ACK) begin
          next_state = WB;
        end
      end
      WB: begin
        if (mode == MODE_FILL) begin
          RF_DATA = data;
          if (cur_is_acc) begin
            RF_ACC_WRITE = 1'b1;
          end else begin
            RF_REG_WRITE = 1'b1;
          end
        end
        next_state = at_last ? FIN : REQ;
      end
      FIN: begin
        DONE       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_spill_ctrl.sv
// tb_reg_spill_ctrl
// Directed bench for reg_spill_ctrl: a table of transfers with hand-computed
// latency and access counts, a register-file and memory model with
// programmable ACK latency, plus hand-written reset-abort and content checks.
module tb_reg_spill_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [3:0] first_reg;
  logic [3:0] last_reg;
  logic [7:0] base_addr;
  logic       busy;
  logic       done;
  logic [3:0] rf_index;
  logic       rf_reg_write;
  logic       rf_acc_write;
  logic       rf_imme;
  logic [7:0] rf_data;
  logic [7:0] rf_reg_in;
  logic [7:0] rf_acc_in;

  reg_spill_ctrl_if #(.W(8), .AW(8)) mem_bus ();

  reg_spill_ctrl #(.W(8), .D(4), .AW(8)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .START        (start),
    .MODE         (mode),
    .FIRST_REG    (first_reg),
    .LAST_REG     (last_reg),
    .BASE_ADDR    (base_addr),
    .BUSY         (busy),
    .DONE         (done),
    .RF_INDEX     (rf_index),
    .RF_REG_WRITE (rf_reg_write),
    .RF_ACC_WRITE (rf_acc_write),
    .RF_IMME      (rf_imme),
    .RF_DATA      (rf_data),
    .RF_REG_IN    (rf_reg_in),
    .RF_ACC_IN    (rf_acc_in),
    .mem          (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file and memory models
  logic [7:0] rf [16];
  logic [7:0] mem [256];
  logic       init_mem;
  logic       ack_en;
  logic       force_ack;
  int         lat;
  int         wait_cnt;

  assign rf_reg_in = (rf_index == 4'd0) ? 8'h00 : rf[rf_index];
  assign rf_acc_in = rf[0];
  assign mem_bus.MEM_RDATA = mem[mem_bus.MEM_ADDR];
  assign mem_bus.MEM_ACK   = force_ack ||
                             (mem_bus.MEM_REQ && ack_en && (wait_cnt >= lat));

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      rf[0] <= 8'h11; rf[1] <= 8'h22; rf[2] <= 8'h33;
      rf[5] <= 8'h50; rf[6] <= 8'h61; rf[7] <= 8'h77;
      rf[8] <= 8'h83; rf[9] <= 8'h94;
      mem[8'h80] <= 8'hA5; mem[8'h81] <= 8'h5A;
      mem[8'hFE] <= 8'hC1; mem[8'hFF] <= 8'hC2; mem[8'h00] <= 8'hC3;
      mem[8'h60] <= 8'hEE;
    end else begin
      if (rf_reg_write) rf[rf_index] <= rf_data;
      if (rf_acc_write) rf[0] <= rf_data;
      if (mem_bus.MEM_REQ && mem_bus.MEM_ACK && mem_bus.MEM_WE)
        mem[mem_bus.MEM_ADDR] <= mem_bus.MEM_WDATA;
    end
    if (mem_bus.MEM_REQ && !mem_bus.MEM_ACK) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  int total;
  int bad;

  task automatic check_output(input string name, input int id,
                              input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s (vec %0d): got %0h expected %0h", name, id, actual, expected);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [3:0] first;
    logic [3:0] last;
    logic [7:0] base;
    int         lat;
    int         inject;
    int         exp_count;
    int         exp_done;
    int         exp_acc;
    logic [7:0] exp_last_addr;
  } vec_t;

  // Runs one transfer, checking every access against the models, and then
  // compares the aggregate counts with the hand-computed record values.
  task automatic apply_stimulus(input vec_t v, input int id);
    int         k;
    int         wr_n;
    int         acc_n;
    int         req_n;
    int         errs;
    int         done_cyc;
    logic [7:0] exp_data;
    logic [7:0] exp_addr;
    logic [7:0] last_addr;
    logic [3:0] idx;
    logic [3:0] last_idx;
    k = 0; wr_n = 0; acc_n = 0; req_n = 0; errs = 0; done_cyc = -1;
    exp_data = 8'h00; last_addr = 8'h00; last_idx = 4'd0;

    @(negedge clk);
    mode = v.mode; first_reg = v.first; last_reg = v.last;
    base_addr = v.base; lat = v.lat; start = 1'b1;
    #1;
    check_output("start_cycle_quiet", id,
                 {28'd0, busy, done, mem_bus.MEM_REQ, rf_reg_write | rf_acc_write}, 32'd0);

    for (int cyc = 1; cyc <= 80 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rf_imme !== 1'b0) errs++;
      if (busy !== 1'b1) errs++;
      if (mem_bus.MEM_REQ) req_n++;
      if (mem_bus.MEM_REQ && mem_bus.MEM_ACK) begin
        exp_addr = v.base + 8'(k);
        idx = v.first + 4'(k);
        if (mem_bus.MEM_ADDR !== exp_addr) errs++;
        if (rf_index !== idx) errs++;
        if (mem_bus.MEM_WE !== ~v.mode) errs++;
        if (!v.mode && (mem_bus.MEM_WDATA !== rf[idx])) errs++;
        exp_data = mem[exp_addr];
        last_addr = mem_bus.MEM_ADDR;
        last_idx = idx;
        k++;
      end
      if (rf_reg_write && rf_acc_write) errs++;
      if (rf_reg_write || rf_acc_write) begin
        wr_n++;
        if (rf_acc_write) acc_n++;
        if (rf_index !== last_idx) errs++;
        if ((rf_index == 4'd0) !== rf_acc_write) errs++;
        if (rf_data !== exp_data) errs++;
      end
      if (done) done_cyc = cyc;
      if (cyc == v.inject) begin
        mode = ~v.mode; first_reg = v.first + 4'd8; last_reg = v.last + 4'd8;
        base_addr = v.base ^ 8'h40; start = 1'b1;
      end
    end
    start = 1'b0;

    check_output("done_cycle", id, done_cyc, v.exp_done);
    check_output("access_count", id, k, v.exp_count);
    check_output("rf_write_count", id, wr_n, v.mode ? v.exp_count : 0);
    check_output("acc_write_count", id, acc_n, v.exp_acc);
    check_output("req_cycles", id, req_n, v.exp_count * (v.lat + 1));
    check_output("last_addr", id, last_addr, v.exp_last_addr);
    check_output("per_cycle_errors", id, errs, 0);
    @(negedge clk);
    check_output("idle_after_fin", id, {30'd0, busy, done}, 32'd0);
  endtask

  vec_t vecs[6];
  vec_t single;

  typedef struct {
    logic       is_rf;
    logic [7:0] addr;
    logic [7:0] val;
  } content_t;
  content_t contents[19];

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; init_mem = 1'b1; start = 1'b0; mode = 1'b0;
    first_reg = 4'd0; last_reg = 4'd0; base_addr = 8'h00;
    ack_en = 1'b1; force_ack = 1'b0; lat = 0;

    vecs[0] = '{1'b0, 4'd0,  4'd2, 8'h40, 0, -1, 3, 7,  0, 8'h42};
    vecs[1] = '{1'b1, 4'd3,  4'd4, 8'h80, 2, -1, 2, 9,  0, 8'h81};
    vecs[2] = '{1'b1, 4'd15, 4'd1, 8'hFE, 0, -1, 3, 7,  1, 8'h00};
    vecs[3] = '{1'b0, 4'd7,  4'd7, 8'h10, 0, -1, 1, 3,  0, 8'h10};
    vecs[4] = '{1'b0, 4'd5,  4'd9, 8'h20, 1, -1, 5, 16, 0, 8'h24};
    vecs[5] = '{1'b0, 4'd0,  4'd2, 8'h50, 0,  2, 3, 7,  0, 8'h52};
    single  = '{1'b0, 4'd7,  4'd7, 8'h30, 0, -1, 1, 3,  0, 8'h30};

    contents[0]  = '{1'b0, 8'h40, 8'h11};
    contents[1]  = '{1'b0, 8'h41, 8'h22};
    contents[2]  = '{1'b0, 8'h42, 8'h33};
    contents[3]  = '{1'b0, 8'h10, 8'h77};
    contents[4]  = '{1'b0, 8'h20, 8'h50};
    contents[5]  = '{1'b0, 8'h21, 8'h61};
    contents[6]  = '{1'b0, 8'h22, 8'h77};
    contents[7]  = '{1'b0, 8'h23, 8'h83};
    contents[8]  = '{1'b0, 8'h24, 8'h94};
    contents[9]  = '{1'b0, 8'h50, 8'hC2};
    contents[10] = '{1'b0, 8'h51, 8'hC3};
    contents[11] = '{1'b0, 8'h52, 8'h33};
    contents[12] = '{1'b0, 8'h30, 8'h77};
    contents[13] = '{1'b1, 8'd3,  8'hA5};
    contents[14] = '{1'b1, 8'd4,  8'h5A};
    contents[15] = '{1'b1, 8'd15, 8'hC1};
    contents[16] = '{1'b1, 8'd0,  8'hC2};
    contents[17] = '{1'b1, 8'd1,  8'hC3};
    contents[18] = '{1'b1, 8'd8,  8'h83};

    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    check_output("reset_outputs", 0,
                 {busy, done, rf_index, rf_reg_write, rf_acc_write, rf_imme, rf_data,
                  mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_ADDR}, 32'd0);
    check_output("reset_wdata", 0, mem_bus.MEM_WDATA, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

    // Reset while a fill is waiting in REQ abandons the transfer.
    @(negedge clk);
    mode = 1'b1; first_reg = 4'd8; last_reg = 4'd10; base_addr = 8'h60;
    lat = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_output("req_before_reset", 6, {31'd0, mem_bus.MEM_REQ}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("reset_busy_drop", 6, {31'd0, busy}, 32'd0);
    check_output("reset_req_drop", 6, {31'd0, mem_bus.MEM_REQ}, 32'd0);
    check_output("reset_strobes_done", 6,
                 {29'd0, rf_reg_write, rf_acc_write, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    #1;
    check_output("late_ack_ignored", 6,
                 {28'd0, busy, done, rf_reg_write, rf_acc_write}, 32'd0);
    @(negedge clk);
    force_ack = 1'b0;
    check_output("still_idle", 6, {30'd0, busy, done}, 32'd0);
    check_output("abandoned_rf8", 6, rf[8], 32'h83);

    apply_stimulus(single, 7);

    for (int i = 0; i < 19; i++) begin
      if (contents[i].is_rf)
        check_output("rf_content", 100 + i, rf[contents[i].addr[3:0]], contents[i].val);
      else
        check_output("mem_content", 100 + i, mem[contents[i].addr], contents[i].val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
